// File: rtl/snake_pkg.sv
// Shared SnakeWars types: top-level game mode, step-sequencer state and
// default step-period constants (in clk cycles).
package snake_pkg;

  typedef enum logic [1:0] {
    MODE_MENU,
    MODE_GAME,
    MODE_OVER,
    MODE_PAUSE
  } game_mode;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    CHECK,
    DRAW
  } step_state;

  localparam int unsigned STEP_BASE_PERIOD = 18750000;
  localparam int unsigned STEP_PERIOD_DEC  = 1250000;
  localparam int unsigned STEP_MIN_PERIOD  = 3125000;

endpackage

// File: rtl/step_tick_gen.sv
// Step period generator: speed level register, level-dependent period and a
// step counter that emits a one-cycle tick every `period` cycles in GAME mode.
module step_tick_gen
  import snake_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = STEP_BASE_PERIOD,
  parameter int unsigned PERIOD_DEC  = STEP_PERIOD_DEC,
  parameter int unsigned MIN_PERIOD  = STEP_MIN_PERIOD,
  parameter int unsigned LEVEL_BITS  = 4,
  parameter int unsigned CTR_BITS    = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  game_i,
  input  logic                  level_up_i,
  output logic                  tick_o,
  output logic [LEVEL_BITS-1:0] level_o
);

  localparam int unsigned PW = CTR_BITS + LEVEL_BITS;
  localparam logic [PW-1:0] BASE_W = PW'(BASE_PERIOD);
  localparam logic [PW-1:0] DEC_W  = PW'(PERIOD_DEC);
  localparam logic [PW-1:0] MIN_W  = PW'(MIN_PERIOD);
  localparam logic [LEVEL_BITS-1:0] LEVEL_MAX = {LEVEL_BITS{1'b1}};

  logic [LEVEL_BITS-1:0] level_q, level_d;
  logic                  game_q;
  logic [CTR_BITS-1:0]   ctr_q, ctr_d;
  logic [PW-1:0]         dec_total, period, ctr_w;
  logic signed [PW:0]    period_raw;
  logic                  tick;

  // One extra sign bit so a large level drives the raw period negative
  // instead of wrapping, and the clamp catches it.
  always_comb begin
    dec_total  = PW'(level_q) * DEC_W;
    period_raw = $signed({1'b0, BASE_W}) - $signed({1'b0, dec_total});
    if (period_raw < $signed({1'b0, MIN_W})) begin
      period = MIN_W;
    end else begin
      period = period_raw[PW-1:0];
    end
  end

  // Compare against the live period so a level change shortens the current count.
  always_comb begin
    ctr_w = PW'(ctr_q);
    tick  = game_i && (ctr_w >= (period - PW'(1)));
  end

  always_comb begin
    ctr_d = ctr_q;
    if (!game_i || tick) begin
      ctr_d = '0;
    end else begin
      ctr_d = ctr_q + CTR_BITS'(1);
    end
  end

  // Entering GAME wins over a coincident level_up.
  always_comb begin
    level_d = level_q;
    if (game_i && !game_q) begin
      level_d = '0;
    end else if (level_up_i && (level_q != LEVEL_MAX)) begin
      level_d = level_q + LEVEL_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      game_q  <= 1'b0;
      ctr_q   <= '0;
    end else begin
      level_q <= level_d;
      game_q  <= game_i;
      ctr_q   <= ctr_d;
    end
  end

  assign tick_o  = tick;
  assign level_o = level_q;

endmodule

// File: rtl/game_step_sched.sv
// SnakeWars game-step scheduler: turns step ticks into MOVE -> CHECK -> DRAW
// req/done sequences. STEP_WATCHDOG_EN adds a per-phase timeout and wd_fault.
module game_step_sched
  import snake_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = STEP_BASE_PERIOD,
  parameter int unsigned PERIOD_DEC  = STEP_PERIOD_DEC,
  parameter int unsigned MIN_PERIOD  = STEP_MIN_PERIOD,
  parameter int unsigned LEVEL_BITS  = 4,
  parameter int unsigned CTR_BITS    = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  game_mode              mode,
  input  logic                  level_up,
  output logic                  move_req,
  input  logic                  move_done,
  output logic                  check_req,
  input  logic                  check_done,
  output logic                  draw_req,
  input  logic                  draw_done,
  output logic                  busy,
  output logic [LEVEL_BITS-1:0] level,
  output logic [15:0]           step_cnt,
  output logic                  overrun
`ifdef STEP_WATCHDOG_EN
  ,
  output logic                  wd_fault
`endif
);

  logic      game;
  logic      tick;
  logic      start;
  logic      phase_done;
  logic      pending_q, pending_d;
  logic      overrun_q, overrun_d;
  step_state state_q;
  logic      move_req_q, check_req_q, draw_req_q, busy_q;
  logic [15:0] step_cnt_q;

  assign game = (mode == MODE_GAME);

  step_tick_gen #(
    .BASE_PERIOD (BASE_PERIOD),
    .PERIOD_DEC  (PERIOD_DEC),
    .MIN_PERIOD  (MIN_PERIOD),
    .LEVEL_BITS  (LEVEL_BITS),
    .CTR_BITS    (CTR_BITS)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .game_i     (game),
    .level_up_i (level_up),
    .tick_o     (tick),
    .level_o    (level)
  );

  // One-deep tick queue; a tick landing on the consuming cycle refills it.
  always_comb begin
    start     = (state_q == IDLE) && pending_q && game;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (!game) begin
      pending_d = 1'b0;
    end else begin
      if (tick && pending_q && !start) begin
        overrun_d = 1'b1;
      end
      if (start) begin
        pending_d = tick;
      end else if (tick) begin
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    phase_done = ((state_q == MOVE)  && move_done)  ||
                 ((state_q == CHECK) && check_done) ||
                 ((state_q == DRAW)  && draw_done);
  end

`ifdef STEP_WATCHDOG_EN
  localparam logic [15:0] WD_LIMIT = 16'hFFFE;
  logic [15:0] wd_q;
  logic        wd_fault_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      move_req_q  <= 1'b0;
      check_req_q <= 1'b0;
      draw_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      step_cnt_q  <= '0;
`ifdef STEP_WATCHDOG_EN
      wd_q        <= '0;
      wd_fault_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= MOVE;
            move_req_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        MOVE: begin
          if (move_done) begin
            state_q     <= CHECK;
            move_req_q  <= 1'b0;
            check_req_q <= 1'b1;
          end
        end
        CHECK: begin
          if (check_done) begin
            state_q     <= DRAW;
            check_req_q <= 1'b0;
            draw_req_q  <= 1'b1;
          end
        end
        DRAW: begin
          if (draw_done) begin
            state_q    <= IDLE;
            draw_req_q <= 1'b0;
            busy_q     <= 1'b0;
            step_cnt_q <= step_cnt_q + 16'd1;
          end
        end
        default: begin
          state_q     <= IDLE;
          move_req_q  <= 1'b0;
          check_req_q <= 1'b0;
          draw_req_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
`ifdef STEP_WATCHDOG_EN
      // Timer restarts on every phase entry; the abort below overrides the case.
      if ((state_q == IDLE) || phase_done) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_q + 16'd1;
      end
      if ((state_q != IDLE) && !phase_done && (wd_q == WD_LIMIT)) begin
        state_q     <= IDLE;
        move_req_q  <= 1'b0;
        check_req_q <= 1'b0;
        draw_req_q  <= 1'b0;
        busy_q      <= 1'b0;
        wd_fault_q  <= 1'b1;
      end
`endif
    end
  end

  assign move_req  = move_req_q;
  assign check_req = check_req_q;
  assign draw_req  = draw_req_q;
  assign busy      = busy_q;
  assign step_cnt  = step_cnt_q;
  assign overrun   = overrun_q;
`ifdef STEP_WATCHDOG_EN
  assign wd_fault  = wd_fault_q;
`endif

endmodule

// File: doc/game_step_sched.md
Name: game_step_sched

Overview:
Game-step scheduler for SnakeWars. It generates the game-step period from the system clock, with a speed level that shortens the period as play progresses. On each step it sequences the downstream units through MOVE -> CHECK -> DRAW using req/done handshakes. It is active only in GAME mode and sits between the top-level mode logic and the snake move, collision and draw units.

Parameters:
BASE_PERIOD, 18750000, clk cycles per step at level 0
PERIOD_DEC, 1250000, cycles removed from the period per level
MIN_PERIOD, 3125000, lower clamp on the period (>=4)
LEVEL_BITS, 4, width of the speed level
CTR_BITS, 25, width of the period counter (must hold BASE_PERIOD)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
mode  in  game_mode  current game mode (snake_pkg)
level_up  in  1  single-cycle pulse; raises the speed level
move_req  out  1  request snake move phase
move_done  in  1  move phase complete
check_req  out  1  request collision check phase
check_done  in  1  check complete
draw_req  out  1  request frame update phase
draw_done  in  1  draw complete
busy  out  1  sequence in progress (state != IDLE)
level  out  LEVEL_BITS  current speed level
step_cnt  out  16  completed step sequences, wraps at 65535->0
overrun  out  1  sticky: a tick arrived while one was already pending

Behaviour:
- Reset values: all req=0, busy=0, level=0, step_cnt=0, overrun=0, ctr=0, pending=0, state IDLE.
- Period: max(MIN_PERIOD, BASE_PERIOD - level*PERIOD_DEC), computed at CTR_BITS+LEVEL_BITS width. A negative intermediate result clamps to MIN_PERIOD.
- Counter: in GAME mode ctr increments each cycle. When ctr >= period-1, tick=1 (internal, one cycle) and ctr<=0 on the next cycle. This gives exactly `period` cycles between ticks. A level change mid-count takes effect immediately; if ctr already exceeds the new period-1, the tick fires at once.
- In non-GAME mode: ctr held at 0, no ticks, pending cleared.
- Level:
  - level_up increments level, saturating at 2^LEVEL_BITS-1.
  - level resets to 0 on rst and on the first cycle of GAME after any non-GAME cycle.
  - If a reset-to-0 and level_up coincide, level=0.
- Pending: a tick sets pending. A second tick while pending=1 sets overrun (sticky until rst); pending stays 1 (one-deep).
- FSM states: IDLE, MOVE, CHECK, DRAW.
  - IDLE: if pending and mode==GAME -> MOVE, clear pending. A tick in the same cycle re-sets pending.
  - MOVE: move_req=1. On move_done=1 -> CHECK; move_req drops in the same cycle the state changes, i.e. req is registered and low the cycle after done is sampled.
  - CHECK: check_req=1; check_done -> DRAW.
  - DRAW: draw_req=1; draw_done -> IDLE, step_cnt+1.
  - At most one req high at any time. done inputs are ignored in states that do not own them.
  - Minimum sequence latency: tick to move_req = 2 cycles (pending registered, then state registered).
- Leaving GAME mid-sequence: the current sequence completes normally (no handshake abort); no new sequence starts.
- rst mid-sequence: immediate return to IDLE, all req low on the next edge.

Optional Feature:
STEP_WATCHDOG_EN:
- When defined: a 16-bit per-phase timer starts at entry to MOVE, CHECK or DRAW. If 65535 cycles pass without the matching done, the FSM forces IDLE, drops the req and sets a sticky output `wd_fault` (extra port, reset 0).
- When undefined: no timer and no wd_fault port; the FSM waits indefinitely.

Decomposition:
- snake_pkg gains `step_state` enum (IDLE, MOVE, CHECK, DRAW) and the default period constants (BASE_PERIOD, PERIOD_DEC, MIN_PERIOD). game_mode is already there.
- One natural sub-module: `step_tick_gen` (counter, period computation, level register, tick output). The FSM stays in the top.

Test Plan (BASE_PERIOD=10, PERIOD_DEC=2, MIN_PERIOD=4, LEVEL_BITS=3):
1. Reset, mode=GAME, done lines respond 1 cycle after req -> ticks every 10 cycles; move_req high 2 cycles after each tick; step_cnt increments once per sequence; never two reqs high together.
2. Three level_up pulses -> period 10,8,6,4. Further pulses keep the period at 4; level saturates at 7.
3. Hold move_done=0 for 25 cycles at period 10 -> pending set at the 2nd tick, overrun=1 at the 3rd tick; after release, exactly one extra sequence runs.
4. mode -> non-GAME during CHECK -> CHECK and DRAW complete, no further move_req, ctr=0. On return to GAME, level=0 and the first tick arrives after 10 cycles.
5. rst asserted during DRAW -> next cycle all reqs=0, busy=0, step_cnt=0, level=0, overrun=0.
6. (STEP_WATCHDOG_EN) Never assert check_done -> after 65535 cycles in CHECK, check_req=0, state IDLE, wd_fault=1.
